// File: rtl/memory_storage_pkg.sv
// Shared geometry for the 64K x 16 data memory.
// Four 16K x 16 single-port banks behind a flat word address.
package memory_storage_pkg;

   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned BANK_SEL_W  = 2;
   localparam int unsigned BANK_ADDR_W = 14;
   localparam int unsigned N_BANKS     = 4;

   typedef logic [BANK_SEL_W-1:0]  bank_sel_t;
   typedef logic [BANK_ADDR_W-1:0] bank_addr_t;
   typedef logic [DATA_W-1:0]      word_t;

endpackage

// File: rtl/memory_storage_spram_bank.sv
// 16K x 16 single-port RAM bank with registered read data.
// Maps to SB_SPRAM256KA on iCE40UP5K, behavioral array elsewhere.
module spram_bank
   import memory_storage_pkg::*;
(
   input  logic                   clk,
   input  logic                   cs,
   input  logic                   we,
   input  logic [BANK_ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout
);

`ifdef ICE40_SPRAM
   SB_SPRAM256KA u_spram (
      .ADDRESS    (addr),
      .DATAIN     (din),
      .MASKWREN   (4'b1111),
      .WREN       (we),
      .CHIPSELECT (cs),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout)
   );
`else
   logic [DATA_W-1:0] mem [2**BANK_ADDR_W];

   // dout only moves on a read, so write cycles leave it untouched
   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) mem[addr] <= din;
         else    dout      <= mem[addr];
      end
   end
`endif

endmodule

// File: rtl/memory_storage.sv
// Unified 64K x 16 data memory over four SPRAM banks.
// One access per clock, read data valid one edge after the address.
module memory_storage
   import memory_storage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout
);

   bank_sel_t  bank;
   bank_addr_t local_addr;
   bank_sel_t  bank_q;
   logic       clr_q;
   logic       rd;
   word_t      bank_dout [N_BANKS];

   assign bank       = address[ADDR_W-1:BANK_ADDR_W];
   assign local_addr = address[BANK_ADDR_W-1:0];
   assign rd         = reset & ~write;

   for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
      logic sel;
      assign sel = reset & (bank == BANK_SEL_W'(i));

      spram_bank u_bank (
         .clk  (clk),
         .cs   (sel),
         .we   (sel & write),
         .addr (local_addr),
         .din  (datain),
         .dout (bank_dout[i])
      );
   end

   // select follows reads only, so writes and bank changes hold the result
   always_ff @(posedge clk) begin
      if (!reset) begin
         clr_q  <= 1'b1;
         bank_q <= '0;
      end else if (rd) begin
         clr_q  <= 1'b0;
         bank_q <= bank;
      end
   end

   assign dataout = clr_q ? '0 : bank_dout[bank_q];

endmodule

// File: tb/tb_memory_storage.sv
// Directed bench for memory_storage.
// Inputs change 1ns after each rising edge; dataout is checked there.
module tb_memory_storage;

   logic        clk = 1'b0;
   logic        reset;
   logic        write;
   logic [15:0] address;
   logic [15:0] datain;
   logic [15:0] dataout;

   int n_chk  = 0;
   int n_pass = 0;

   memory_storage dut (
      .clk     (clk),
      .reset   (reset),
      .write   (write),
      .address (address),
      .datain  (datain),
      .dataout (dataout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %04h want %04h", tag, got, exp);
   endtask

   task automatic cyc(input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
      reset   = r;
      write   = w;
      address = a;
      datain  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      cyc(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [15:0] a, input string tag,
                     input logic [15:0] exp);
      cyc(1'b1, 1'b0, a, 16'h0000);
      chk(tag, dataout, exp);
   endtask

   initial begin
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("reset_init", dataout, 16'h0000);

      wr(16'h0000, 16'h0001);
      wr(16'h4000, 16'h0002);
      wr(16'h8000, 16'h0003);
      wr(16'hA000, 16'h0004);
      chk("after_writes", dataout, 16'h0000);
      rd(16'h0000, "spread_0000", 16'h0001);
      rd(16'h4000, "spread_4000", 16'h0002);
      rd(16'h8000, "spread_8000", 16'h0003);
      rd(16'hA000, "spread_A000", 16'h0004);

      wr(16'h8000, 16'h1111);
      wr(16'hA000, 16'h2222);
      rd(16'h8000, "alias_8000", 16'h1111);
      rd(16'hA000, "alias_A000", 16'h2222);

      wr(16'h3FFF, 16'h00A1);
      wr(16'h4000, 16'h00A2);
      wr(16'hBFFF, 16'h00A3);
      wr(16'hC000, 16'h00A4);
      wr(16'hFFFF, 16'h00A5);
      rd(16'h3FFF, "bnd_3FFF", 16'h00A1);
      rd(16'h4000, "bnd_4000", 16'h00A2);
      rd(16'hBFFF, "bnd_BFFF", 16'h00A3);
      rd(16'hC000, "bnd_C000", 16'h00A4);
      rd(16'hFFFF, "bnd_FFFF", 16'h00A5);
      rd(16'h8000, "bnd_8000", 16'h1111);

      rd(16'h0000, "hold_pre", 16'h0001);
      wr(16'h4000, 16'hBEEF);
      chk("hold_wr", dataout, 16'h0001);
      rd(16'h4000, "hold_post", 16'hBEEF);

      cyc(1'b0, 1'b1, 16'h0000, 16'hDEAD);
      chk("rst_cyc1", dataout, 16'h0000);
      cyc(1'b0, 1'b1, 16'h0000, 16'hDEAD);
      chk("rst_cyc2", dataout, 16'h0000);
      rd(16'h0000, "rst_keep", 16'h0001);

      rd(16'h0000, "b2b_0000", 16'h0001);
      rd(16'hC000, "b2b_C000", 16'h00A4);
      rd(16'h4000, "b2b_4000", 16'hBEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
